// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of a single-cycle-latency ALU.
// Owns a 32-entry register file, issues one instruction at a time and commits ALU results.
module alu_issue #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-27:0] i_in_op,
  input  logic [4:0]       i_in_rs1,
  input  logic [4:0]       i_in_rs2,
  input  logic [4:0]       i_in_rd,
  input  logic [WIDTH-1:0] i_in_imm,
  input  logic             i_in_use_imm,
  output logic             o_alu_en,
  output logic [WIDTH-27:0] o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_valid,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_rd,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_err,
  input  logic [4:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  localparam int unsigned OpW        = WIDTH - 26;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           r_state, w_state_d;
  logic [7:0]       r_cnt, w_cnt_d, w_cnt_inc;
  logic             r_alu_en, w_alu_en_d;
  logic [OpW-1:0]   r_alu_op, w_alu_op_d;
  logic [WIDTH-1:0] r_alu_a, w_alu_a_d;
  logic [WIDTH-1:0] r_alu_b, w_alu_b_d;
  logic [4:0]       r_rd, w_rd_d;
  logic             r_wb_valid, w_wb_valid_d;
  logic [4:0]       r_wb_rd, w_wb_rd_d;
  logic [WIDTH-1:0] r_wb_data, w_wb_data_d;
  logic             r_err, w_err_d;
  logic             w_rf_we;
  logic [WIDTH-1:0] r_rf [32];
  logic [WIDTH-1:0] w_rs1_val, w_rs2_val;

  // x0 is never written, but gate reads anyway so it is zero by construction.
  assign w_rs1_val = (i_in_rs1 == 5'd0) ? '0 : r_rf[i_in_rs1];
  assign w_rs2_val = (i_in_rs2 == 5'd0) ? '0 : r_rf[i_in_rs2];
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_alu_en_d   = 1'b0;
    w_alu_op_d   = r_alu_op;
    w_alu_a_d    = r_alu_a;
    w_alu_b_d    = r_alu_b;
    w_rd_d       = r_rd;
    w_wb_valid_d = 1'b0;
    w_wb_rd_d    = r_wb_rd;
    w_wb_data_d  = r_wb_data;
    w_err_d      = r_err;
    w_rf_we      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_alu_op_d = i_in_op;
          w_alu_a_d  = w_rs1_val;
          w_alu_b_d  = i_in_use_imm ? i_in_imm : w_rs2_val;
          w_rd_d     = i_in_rd;
          w_alu_en_d = 1'b1;
          w_state_d  = StIssue;
        end
      end
      StIssue: begin
        w_cnt_d   = 8'd0;
        w_state_d = StWait;
      end
      StWait: begin
        if (i_alu_valid) begin
          w_rf_we      = (r_rd != 5'd0);
          w_wb_valid_d = 1'b1;
          w_wb_rd_d    = r_rd;
          w_wb_data_d  = i_alu_result;
          w_state_d    = StIdle;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == TimeoutCnt) begin
            w_err_d   = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= 8'd0;
      r_alu_en   <= 1'b0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_alu_en   <= w_alu_en_d;
      r_alu_op   <= w_alu_op_d;
      r_alu_a    <= w_alu_a_d;
      r_alu_b    <= w_alu_b_d;
      r_rd       <= w_rd_d;
      r_wb_valid <= w_wb_valid_d;
      r_wb_rd    <= w_wb_rd_d;
      r_wb_data  <= w_wb_data_d;
      r_err      <= w_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_rf[r_rd] <= i_alu_result;
    end
  end

  // Ready is masked while reset is held so nothing looks acceptable before release.
  assign o_in_ready = (r_state == StIdle) && !i_rst;
  assign o_alu_en   = r_alu_en;
  assign o_alu_op   = r_alu_op;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;
  assign o_err      = r_err;
  assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_rf[i_dbg_addr];

endmodule
